// File: rtl/cv32e41p_pkg.sv
// Shared EX-stage types for the serial divider: opcodes, FSM states and iteration count.
// Optional early-out behaviour of the divider is selected with CV32E41P_DIV_FASTPATH_EN.
package cv32e41p_pkg;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_opcode_e;

    typedef enum logic [1:0] {
        IDLE_DIV   = 2'd0,
        DIVIDE     = 2'd1,
        FINISH_DIV = 2'd2
    } div_state_e;

    localparam int unsigned DIV_XLEN       = 32;
    localparam int unsigned DIV_ITERATIONS = 32;
    localparam int unsigned DIV_CNT_W      = $clog2(DIV_ITERATIONS);

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, which the divider relies on.
    function automatic logic [DIV_XLEN-1:0] divAbs(input logic [DIV_XLEN-1:0] value,
                                                   input logic                isSigned);
        return (isSigned && value[DIV_XLEN-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/cv32e41p_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder
// and keep the difference only if the divisor fits.
module cv32e41p_div_step
    import cv32e41p_pkg::*;
(
    input  logic [DIV_XLEN-1:0] i_rem,
    input  logic [DIV_XLEN-1:0] i_quot,
    input  logic [DIV_XLEN-1:0] i_div,
    output logic [DIV_XLEN-1:0] o_rem,
    output logic [DIV_XLEN-1:0] o_quot
);

    logic [DIV_XLEN:0] w_part;
    logic [DIV_XLEN:0] w_diff;

    assign w_part = {i_rem, i_quot[DIV_XLEN-1]};
    assign w_diff = w_part - {1'b0, i_div};

    // The top bit is the borrow; the kept remainder always fits in DIV_XLEN bits.
    assign o_rem  = w_diff[DIV_XLEN] ? w_part[DIV_XLEN-1:0] : w_diff[DIV_XLEN-1:0];
    assign o_quot = {i_quot[DIV_XLEN-2:0], ~w_diff[DIV_XLEN]};

endmodule

// File: rtl/cv32e41p_div_serial.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle, multiplier-style handshake.
// Define CV32E41P_DIV_FASTPATH_EN to finish divide-by-zero and |a| < |b| immediately at accept.
module cv32e41p_div_serial
    import cv32e41p_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  div_opcode_e         operator_i,
    input  logic [DIV_XLEN-1:0] op_a_i,
    input  logic [DIV_XLEN-1:0] op_b_i,
    output logic [DIV_XLEN-1:0] result_o,
    output logic                multicycle_o,
    output logic                ready_o,
    input  logic                ex_ready_i
);

    div_state_e           r_state;
    div_opcode_e          r_op;
    logic [DIV_XLEN-1:0]  r_quot;
    logic [DIV_XLEN-1:0]  r_rem;
    logic [DIV_XLEN-1:0]  r_div;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic                 r_negQuot;
    logic                 r_negRem;

    logic                 w_signed;
    logic [DIV_XLEN-1:0]  w_absA;
    logic [DIV_XLEN-1:0]  w_absB;
    logic                 w_negQuot;
    logic                 w_negRem;
    logic [DIV_XLEN-1:0]  w_stepRem;
    logic [DIV_XLEN-1:0]  w_stepQuot;

    assign w_signed  = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
    assign w_absA    = divAbs(op_a_i, w_signed);
    assign w_absB    = divAbs(op_b_i, w_signed);
    // A zero divisor must yield all-ones for DIV too, so the quotient sign flip is suppressed.
    assign w_negQuot = w_signed && (op_a_i[DIV_XLEN-1] ^ op_b_i[DIV_XLEN-1]) && (op_b_i != '0);
    assign w_negRem  = w_signed && op_a_i[DIV_XLEN-1];

`ifdef CV32E41P_DIV_FASTPATH_EN
    logic w_fastZero;
    logic w_fastSmall;
    assign w_fastZero  = (op_b_i == '0);
    assign w_fastSmall = (w_absA < w_absB);
`endif

    cv32e41p_div_step u_step (
        .i_rem  (r_rem),
        .i_quot (r_quot),
        .i_div  (r_div),
        .o_rem  (w_stepRem),
        .o_quot (w_stepQuot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE_DIV;
            r_op      <= DIV_DIV;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
        end else begin
            case (r_state)
                IDLE_DIV: begin
                    if (enable_i) begin
                        r_op      <= operator_i;
                        r_div     <= w_absB;
                        r_negQuot <= w_negQuot;
                        r_negRem  <= w_negRem;
                        r_cnt     <= DIV_CNT_W'(DIV_ITERATIONS - 1);
`ifdef CV32E41P_DIV_FASTPATH_EN
                        if (w_fastZero) begin
                            r_quot  <= '1;
                            r_rem   <= w_absA;
                            r_state <= FINISH_DIV;
                        end else if (w_fastSmall) begin
                            r_quot  <= '0;
                            r_rem   <= w_absA;
                            r_state <= FINISH_DIV;
                        end else begin
                            r_quot  <= w_absA;
                            r_rem   <= '0;
                            r_state <= DIVIDE;
                        end
`else
                        r_quot  <= w_absA;
                        r_rem   <= '0;
                        r_state <= DIVIDE;
`endif
                    end
                end
                DIVIDE: begin
                    r_quot <= w_stepQuot;
                    r_rem  <= w_stepRem;
                    r_cnt  <= r_cnt - DIV_CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= FINISH_DIV;
                    end
                end
                FINISH_DIV: begin
                    if (ex_ready_i) begin
                        r_state <= IDLE_DIV;
                    end
                end
                default: r_state <= IDLE_DIV;
            endcase
        end
    end

    always_comb begin
        result_o = '0;
        if (r_state == FINISH_DIV) begin
            if ((r_op == DIV_DIV) || (r_op == DIV_DIVU)) begin
                result_o = r_negQuot ? (~r_quot + 1'b1) : r_quot;
            end else begin
                result_o = r_negRem ? (~r_rem + 1'b1) : r_rem;
            end
        end
    end

    assign multicycle_o = (r_state == DIVIDE);
    assign ready_o      = ((r_state == IDLE_DIV) && !enable_i) || (r_state == FINISH_DIV);

endmodule
